// File: rtl/ce_sequencer_pkg.sv
// Shared constants and decode helpers for the ce_sequencer clock-enable block.
package ce_sequencer_pkg;

   typedef enum logic [1:0] {
      CPU_MODE_3M     = 2'd0,
      CPU_MODE_6M     = 2'd1,
      CPU_MODE_1M5    = 2'd2,
      CPU_MODE_3M_ALT = 2'd3
   } cpu_mode_e;

   typedef enum logic {
      ST_HOLD = 1'b0,
      ST_RUN  = 1'b1
   } seq_state_e;

   // NCO increments for a 32-bit accumulator clocked at 24 MHz
   localparam logic [31:0] INC_PAL_FSC = 32'd3173707922;  // 4 x 4.43361875 MHz
   localparam logic [31:0] INC_18M432  = 32'd3298534883;  // 18.432 MHz

   function automatic logic cpu_tick(input cpu_mode_e mode, input logic [3:0] c);
      case (mode)
         CPU_MODE_6M:  return c[1:0] == 2'd2;
         CPU_MODE_1M5: return c == 4'd6;
         default:      return c[2:0] == 3'd6;
      endcase
   endfunction

endpackage

// File: rtl/ce_sequencer_nco.sv
// One NCO channel: phase accumulator with programmable increment, carry and MSB outputs.
module nco_channel #(
   parameter int unsigned      ACC_W     = 32,
   parameter logic [ACC_W-1:0] INC_RESET = '0
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             we_i,
   input  logic [ACC_W-1:0] inc_i,
   output logic             ce_o,
   output logic             msb_o
);

   logic [ACC_W-1:0] acc_q, acc_d;
   logic [ACC_W-1:0] inc_q, inc_d;
   logic             carry_d;
   logic             ce_q, msb_q;

   always_comb begin
      {carry_d, acc_d} = {1'b0, acc_q} + {1'b0, inc_q};
      inc_d            = we_i ? inc_i : inc_q;
   end

   // Accumulator is never cleared on an increment write, keeping phase continuous
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         acc_q <= '0;
         inc_q <= INC_RESET;
         ce_q  <= 1'b0;
         msb_q <= 1'b0;
      end else begin
         acc_q <= acc_d;
         inc_q <= inc_d;
         ce_q  <= carry_d;
         msb_q <= acc_d[ACC_W-1];
      end
   end

   assign ce_o  = ce_q;
   assign msb_o = msb_q;

endmodule

// File: rtl/ce_sequencer.sv
// Clock-enable sequencer on clk24: master counter with reset holdoff, video strobes,
// glitch-free CPU enable and NCH programmable NCO channels.
module ce_sequencer
   import ce_sequencer_pkg::*;
#(
   parameter int unsigned          CTR_W       = 6,
   parameter int unsigned          INIT_CYCLES = 3,
   parameter int unsigned          NCH         = 4,
   parameter int unsigned          ACC_W       = 32,
   parameter logic [NCH*ACC_W-1:0] INC_DEFAULT = '0
) (
   input  logic             clk24,
   input  logic             reset,
   input  logic [1:0]       cpu_mode,
   input  logic             cpu_hold,
   input  logic             inc_we,
   input  logic [2:0]       inc_sel,
   input  logic [ACC_W-1:0] inc_data,
   output logic             ce12,
   output logic             ce6,
   output logic             ce6x,
   output logic             ce3,
   output logic             ce1m5,
   output logic             video_slice,
   output logic             pipe_ab,
   output logic             ce_cpu,
   output logic [NCH-1:0]   nco_clk,
   output logic [NCH-1:0]   nco_ce
);

   localparam int unsigned INIT_W = $clog2(INIT_CYCLES + 1);

   seq_state_e        state_q, state_d;
   logic [INIT_W-1:0] init_q, init_d;
   logic [CTR_W-1:0]  ctr_q, ctr_d;
   cpu_mode_e         mode_q, mode_d;
   logic [7:0]        strb_q, strb_d;

   always_comb begin
      state_d = state_q;
      init_d  = init_q;
      ctr_d   = ctr_q;
      mode_d  = mode_q;
      strb_d  = '0;
      case (state_q)
         ST_HOLD: begin
            init_d = init_q + INIT_W'(1);
            if (init_q == INIT_W'(INIT_CYCLES - 1)) state_d = ST_RUN;
         end
         ST_RUN: begin
            ctr_d = ctr_q + CTR_W'(1);
            // Mode only changes at the 8-cycle slot end, so no CPU period is ever shortened
            if (ctr_q[2:0] == 3'd7) mode_d = cpu_mode_e'(cpu_mode);
            strb_d = {ctr_q[0],
                      &ctr_q[1:0],
                      ctr_q[1] & ~ctr_q[0],
                      ctr_q[2:0] == 3'd6,
                      ctr_q[3:0] == 4'd6,
                      ~ctr_q[2],
                      ctr_q[CTR_W-1],
                      ~cpu_hold & cpu_tick(mode_q, ctr_q[3:0])};
         end
         default: state_d = ST_HOLD;
      endcase
   end

   always_ff @(posedge clk24) begin
      if (reset) begin
         state_q <= ST_HOLD;
         init_q  <= '0;
         ctr_q   <= '0;
         mode_q  <= CPU_MODE_3M;
         strb_q  <= '0;
      end else begin
         state_q <= state_d;
         init_q  <= init_d;
         ctr_q   <= ctr_d;
         mode_q  <= mode_d;
         strb_q  <= strb_d;
      end
   end

   assign {ce12, ce6, ce6x, ce3, ce1m5, video_slice, pipe_ab, ce_cpu} = strb_q;

   for (genvar i = 0; i < NCH; i++) begin : g_nco
      nco_channel #(
         .ACC_W     (ACC_W),
         .INC_RESET (INC_DEFAULT[i*ACC_W +: ACC_W])
      ) u_nco (
         .clk_i   (clk24),
         .reset_i (reset),
         .we_i    (inc_we && (inc_sel == 3'(i))),
         .inc_i   (inc_data),
         .ce_o    (nco_ce[i]),
         .msb_o   (nco_clk[i])
      );
   end

endmodule
